// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    localparam int DMEM_ADDR_WIDTH = 5;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_LOCK_MAX   = 8;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; also reports where the pointer goes if the grant is taken.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_nxt_o
);

    always_comb begin
        gnt_o     = req_i;
        ptr_nxt_o = ptr_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
        // The pointer always lands on the requester that lost (or was absent).
        if (gnt_o[0]) begin
            ptr_nxt_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_nxt_o = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory, with an
// atomic-sequence lock that is force-released after LOCK_MAX cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int LOCK_MAX   = DMEM_LOCK_MAX
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  r0_valid_i,
    input  logic                  r0_we_i,
    input  logic                  r0_lock_i,
    input  logic [ADDR_WIDTH-1:0] r0_addr_i,
    input  logic [DATA_WIDTH-1:0] r0_wdata_i,
    output logic                  r0_ready_o,
    output logic                  r0_rvalid_o,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,
    input  logic                  r1_valid_i,
    input  logic                  r1_we_i,
    input  logic                  r1_lock_i,
    input  logic [ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [DATA_WIDTH-1:0] r1_wdata_i,
    output logic                  r1_ready_o,
    output logic                  r1_rvalid_o,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    localparam int               CNT_W    = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] rr_gnt;
    logic       rr_ptr_nxt;
    logic [1:0] gnt;
    logic       sel;
    logic       lock_sel;
    logic       rd_acc0, rd_acc1;

    logic                  r0_rvalid_q, r1_rvalid_q;
    logic [DATA_WIDTH-1:0] r0_rdata_q, r1_rdata_q;

    rr_arb2 u_rr_arb2 (
        .req_i     ({r1_valid_i, r0_valid_i}),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt),
        .ptr_nxt_o (rr_ptr_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB;
            owner_q <= REQ_CORE;
            ptr_q   <= REQ_CORE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        lock_sel = sel ? r1_lock_i : r0_lock_i;
        case (state_q)
            ARB: begin
                if (|gnt) begin
                    ptr_d = rr_ptr_nxt;
                    if (lock_sel) begin
                        state_d = LOCKED;
                        owner_d = sel;
                        cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Timeout wins over a same-cycle lock request; the access itself still goes through.
                if ((cnt_q == CNT_LAST) || ((|gnt) && !lock_sel)) begin
                    state_d = ARB;
                    ptr_d   = other_req(owner_q);
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_comb begin
        gnt = 2'b00;
        if (rst_ni) begin
            if (state_q == ARB) begin
                gnt = rr_gnt;
            end else if (owner_q == REQ_AUX) begin
                gnt = {r1_valid_i, 1'b0};
            end else begin
                gnt = {1'b0, r0_valid_i};
            end
        end
        sel        = gnt[REQ_AUX];
        mem_addr_o = sel ? r1_addr_i  : r0_addr_i;
        mem_wd_o   = sel ? r1_wdata_i : r0_wdata_i;
        mem_we_o   = (|gnt) & (sel ? r1_we_i : r0_we_i);
        r0_ready_o = gnt[REQ_CORE];
        r1_ready_o = gnt[REQ_AUX];
    end

    assign rd_acc0 = gnt[REQ_CORE] & ~r0_we_i;
    assign rd_acc1 = gnt[REQ_AUX]  & ~r1_we_i;

    // Read data is captured at the accept edge so it is valid in the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            r0_rvalid_q <= rd_acc0;
            r1_rvalid_q <= rd_acc1;
            if (rd_acc0) begin
                r0_rdata_q <= mem_rd_i;
            end
            if (rd_acc1) begin
                r1_rdata_q <= mem_rd_i;
            end
        end
    end

    assign r0_rvalid_o = r0_rvalid_q;
    assign r1_rvalid_o = r1_rvalid_q;
    assign r0_rdata_o  = r0_rdata_q;
    assign r1_rdata_o  = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter against a behavioural arbiter model.
module tb_dmem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk;
    logic          rst_n;
    logic          r0_valid, r0_we, r0_lock, r1_valid, r1_we, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          mem_we;

    logic [DW-1:0] env_mem [2**AW];
    logic          preload;

    int n_chk;
    int n_pass;

    // model state
    logic [DW-1:0] m_mem [2**AW];
    bit            m_locked;
    int            m_owner;
    int            m_prio;
    int            m_held;
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];

    // last sampled DUT outputs
    logic          s_rdy0, s_rdy1, s_we, s_rv0, s_rv1;
    logic [DW-1:0] s_rd0;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .r0_valid_i  (r0_valid),
        .r0_we_i     (r0_we),
        .r0_lock_i   (r0_lock),
        .r0_addr_i   (r0_addr),
        .r0_wdata_i  (r0_wdata),
        .r0_ready_o  (r0_ready),
        .r0_rvalid_o (r0_rvalid),
        .r0_rdata_o  (r0_rdata),
        .r1_valid_i  (r1_valid),
        .r1_we_i     (r1_we),
        .r1_lock_i   (r1_lock),
        .r1_addr_i   (r1_addr),
        .r1_wdata_i  (r1_wdata),
        .r1_ready_o  (r1_ready),
        .r1_rvalid_o (r1_rvalid),
        .r1_rdata_o  (r1_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wd_o    (mem_wd),
        .mem_we_o    (mem_we),
        .mem_rd_i    (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2**AW; i++) env_mem[i] <= init_word(i);
        end else if (mem_we) begin
            env_mem[mem_addr] <= mem_wd;
        end
    end
    assign mem_rd = env_mem[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_prio   = 0;
        m_held   = 0;
        m_rv[0]  = 1'b0;
        m_rv[1]  = 1'b0;
        m_rd[0]  = '0;
        m_rd[1]  = '0;
    endtask

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        model_reset();
        repeat (ncyc) begin
            @(negedge clk);
            check_val("rst_ready0", r0_ready, 0);
            check_val("rst_ready1", r1_ready, 0);
            check_val("rst_mem_we", mem_we, 0);
            check_val("rst_rvalid0", r0_rvalid, 0);
            check_val("rst_rvalid1", r1_rvalid, 0);
            check_val("rst_rdata0", r0_rdata, 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        r0_valid = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    // One clock of stimulus: drive, check against the model at negedge, advance the model.
    task automatic cyc(input logic v0, input logic we0, input logic lk0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic lk1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic          vv [2];
        logic          ww [2];
        logic          ll [2];
        logic [AW-1:0] aa [2];
        logic [DW-1:0] dd [2];
        int            w;
        r0_valid = v0; r0_we = we0; r0_lock = lk0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_lock = lk1; r1_addr = a1; r1_wdata = d1;
        vv[0] = v0; ww[0] = we0; ll[0] = lk0; aa[0] = a0; dd[0] = d0;
        vv[1] = v1; ww[1] = we1; ll[1] = lk1; aa[1] = a1; dd[1] = d1;
        @(negedge clk);
        w = -1;
        if (!m_locked) begin
            if (v0 && v1) w = m_prio;
            else if (v0) w = 0;
            else if (v1) w = 1;
        end else if (vv[m_owner]) begin
            w = m_owner;
        end
        s_rdy0 = r0_ready; s_rdy1 = r1_ready; s_we = mem_we;
        s_rv0 = r0_rvalid; s_rv1 = r1_rvalid; s_rd0 = r0_rdata;
        check_val("ready0", r0_ready, 32'(w == 0));
        check_val("ready1", r1_ready, 32'(w == 1));
        check_val("mem_we", mem_we, 32'((w >= 0) && ww[(w >= 0) ? w : 0]));
        if (w >= 0) begin
            check_val("mem_addr", mem_addr, aa[w]);
            if (ww[w]) check_val("mem_wd", mem_wd, dd[w]);
        end else begin
            check_val("mem_addr_idle", mem_addr, a0);
        end
        check_val("rvalid0", r0_rvalid, m_rv[0]);
        check_val("rvalid1", r1_rvalid, m_rv[1]);
        check_val("rdata0", r0_rdata, m_rd[0]);
        check_val("rdata1", r1_rdata, m_rd[1]);
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (w >= 0) begin
            if (ww[w]) m_mem[aa[w]] = dd[w];
            else begin
                m_rv[w] = 1'b1;
                m_rd[w] = m_mem[aa[w]];
            end
        end
        if (!m_locked) begin
            if (w >= 0) begin
                m_prio = 1 - w;
                if (ll[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_held   = 0;
                end
            end
        end else begin
            m_held++;
            if ((m_held == LM) || ((w >= 0) && !ll[w])) begin
                m_locked = 1'b0;
                m_prio   = 1 - m_owner;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        preload = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2**AW; i++) m_mem[i] = init_word(i);
        model_reset();
        @(posedge clk);
        #1;
        preload = 1'b0;

        // reset held with a pending write request
        r0_valid = 1; r0_we = 1; r0_addr = 5'd7; r0_wdata = 32'h1234_5678;
        apply_reset(3);
        cyc(1, 1, 0, 5'd7, 32'h1234_5678, 0, 0, 0, 5'd0, 32'h0);
        check_val("t1_ready0", s_rdy0, 1);
        check_val("t1_mem_we", s_we, 1);

        // read-after-write on the same address
        cyc(1, 1, 0, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 5'd0, 32'h0);
        cyc(1, 0, 0, 5'd3, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        cyc(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        check_val("t2_rvalid0", s_rv0, 1);
        check_val("t2_rdata0", s_rd0, 32'hDEAD_BEEF);
        check_val("t2_rvalid1", s_rv1, 0);

        // both reading from reset: grants alternate
        idle_inputs();
        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 5'(i), 32'h0, 1, 0, 0, 5'(i + 10), 32'h0);
            check_val("t3_grant1", s_rdy1, 32'(i % 2));
        end
        cyc(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        check_val("t3_last_rv1", s_rv1, 1);

        // r1 locked read-modify-write while r0 keeps asking
        cyc(1, 1, 0, 5'd9, 32'hA5A5_0001, 0, 0, 0, 5'd0, 32'h0);
        cyc(1, 0, 0, 5'd1, 32'h0, 1, 0, 1, 5'd5, 32'h0);
        check_val("t4_a_ready0", s_rdy0, 0);
        check_val("t4_a_ready1", s_rdy1, 1);
        cyc(1, 0, 0, 5'd1, 32'h0, 1, 1, 0, 5'd5, 32'hCAFE_F00D);
        check_val("t4_b_ready0", s_rdy0, 0);
        cyc(1, 0, 0, 5'd1, 32'h0, 1, 0, 0, 5'd5, 32'h0);
        check_val("t4_c_ready0", s_rdy0, 1);

        // lock held past LOCK_MAX is forced off
        idle_inputs();
        apply_reset(1);
        for (int i = 0; i < LM + 2; i++) begin
            cyc(1, 0, 1, 5'(i), 32'h0, 1, 0, 0, 5'd6, 32'h0);
            if (i < LM + 1) check_val("t5_owner_ready", s_rdy0, 1);
            else check_val("t5_release_ready1", s_rdy1, 1);
        end

        // reset right after a read accept drops the response
        idle_inputs();
        apply_reset(1);
        cyc(1, 0, 0, 5'd2, 32'h0, 0, 0, 0, 5'd0, 32'h0);
        idle_inputs();
        apply_reset(2);
        cyc(1, 0, 0, 5'd4, 32'h0, 1, 0, 0, 5'd8, 32'h0);
        check_val("t6_prio0", s_rdy0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) apply_reset(1);
            cyc($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                5'($urandom_range(0, 31)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
